// File: rtl/sink_pkg.sv
// sink_pkg: shared types and constants for the stream sink checker slice.
// Holds the FSM state enum, LFSR taps, counter width and a saturating increment.
package sink_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam int         CNT_W     = 32;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lfsr8.sv
// lfsr8: 8-bit Galois LFSR, loads the seed on reset and steps when enabled.
// A zero seed would lock the register, so it is replaced by 8'h01.
module lfsr8
    import sink_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] seed,
    output logic [7:0] state
);

    logic [7:0] state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= (seed == 8'h00) ? 8'h01 : seed;
        end else if (en) begin
            state_q <= {1'b0, state_q[7:1]}
                     ^ (state_q[0] ? LFSR_TAPS : 8'h00);
        end
    end

    assign state = state_q;

endmodule

// File: rtl/stream_sink_checker.sv
// stream_sink_checker: req/ack sink checking an affine golden sequence.
// Optional idle watchdog with a timeout port: STREAM_SINK_CHECKER_TIMEOUT_EN.
module stream_sink_checker
    import sink_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned EXP_INIT     = 2,
    parameter int unsigned EXP_STEP     = 3,
    parameter int unsigned MAX_COUNT    = 5000,
    parameter int unsigned STALL_THRESH = 0,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT      = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  req,
    input  logic                  ack,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [CNT_W-1:0]      count,
    output logic [CNT_W-1:0]      err_count,
    output logic [CNT_W-1:0]      first_err_idx,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic [CNT_W-1:0]      run_cycles,
    output logic                  proto_err,
    output logic                  done,
    output logic                  pass
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
    ,
    output logic                  timeout
`endif
);

    localparam logic [DATA_WIDTH-1:0] EXP_INIT_W = DATA_WIDTH'(EXP_INIT);
    localparam logic [DATA_WIDTH-1:0] EXP_STEP_W = DATA_WIDTH'(EXP_STEP);
    localparam logic [CNT_W-1:0]      MAX_W      = CNT_W'(MAX_COUNT);

    state_t                state_q, state_d;
    logic [7:0]            lfsr;
    logic                  stall, accept, mismatch, proto_hit;
    logic                  hit_max, err_zero_d, pass_d;
    logic                  req_q, req_prev_q, proto_q, pass_q;
    logic [DATA_WIDTH-1:0] exp_q, fdata_q;
    logic [CNT_W-1:0]      count_q, err_q, fidx_q, run_q, count_inc;
    logic                  idle_hit, timeout_q;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .seed  (LFSR_SEED),
        .state (lfsr)
    );

    assign stall     = ({1'b0, lfsr} < 9'(STALL_THRESH));
    assign accept    = ack && (state_q == RUN);
    assign mismatch  = (din != exp_q);
    // ack is legal only in RUN and only after a cycle with req high
    assign proto_hit = ack && ((state_q != RUN) || !req_prev_q);
    assign count_inc = sat_inc(count_q);
    assign hit_max   = (count_inc == MAX_W);

`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
    logic [CNT_W-1:0] idle_q, idle_inc;

    assign idle_inc = sat_inc(idle_q);
    assign idle_hit = (state_q == RUN) && !accept
                    && (idle_inc >= CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == RUN) begin
                idle_q <= accept ? '0 : idle_inc;
            end
            if (idle_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign idle_hit  = 1'b0;
    assign timeout_q = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if ((accept && hit_max) || idle_hit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // verdict is computed from next-state values so it is valid in DONE's first cycle
    assign err_zero_d = (err_q == '0) && !(accept && mismatch);
    assign pass_d     = (state_d == DONE) && err_zero_d
                      && !proto_q && !proto_hit
                      && !timeout_q && !idle_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            req_prev_q <= 1'b0;
            exp_q      <= EXP_INIT_W;
            count_q    <= '0;
            err_q      <= '0;
            fidx_q     <= '0;
            fdata_q    <= '0;
            run_q      <= '0;
            proto_q    <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= (state_d == RUN) && !stall;
            req_prev_q <= req_q;
            pass_q     <= pass_d;
            if (state_q == RUN) begin
                run_q <= sat_inc(run_q);
            end
            if (accept) begin
                count_q <= count_inc;
                exp_q   <= exp_q + EXP_STEP_W;
                if (mismatch) begin
                    err_q <= sat_inc(err_q);
                    if (err_q == '0) begin
                        fidx_q  <= count_q;
                        fdata_q <= din;
                    end
                end
            end
            if (proto_hit) begin
                proto_q <= 1'b1;
            end
        end
    end

    assign req            = req_q;
    assign count          = count_q;
    assign err_count      = err_q;
    assign first_err_idx  = fidx_q;
    assign first_err_data = fdata_q;
    assign run_cycles     = run_q;
    assign proto_err      = proto_q;
    assign done           = (state_q == DONE);
    assign pass           = pass_q;

endmodule

// File: tb/tb_stream_sink_checker.sv
// tb_stream_sink_checker: randomized upstream against a behavioural sink model.
// Define STREAM_SINK_CHECKER_TIMEOUT_EN to also exercise the watchdog.
module tb_stream_sink_checker;

    localparam int unsigned MAXC   = 5000;
    localparam int unsigned INIT   = 2;
    localparam int unsigned STEP   = 3;
    localparam int unsigned THR    = 128;
    localparam logic [7:0]  SEED   = 8'hA5;
    localparam int unsigned TMO    = 16;
    localparam int          BUDGET = 40000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ack = 1'b0;
    logic [31:0] din = '0;
    logic        req, proto_err, done, pass;
    logic [31:0] count, err_count, first_err_idx, first_err_data, run_cycles;
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
    logic        timeout;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stream_sink_checker #(
        .DATA_WIDTH   (32),
        .EXP_INIT     (INIT),
        .EXP_STEP     (STEP),
        .MAX_COUNT    (MAXC),
        .STALL_THRESH (THR),
        .LFSR_SEED    (SEED)
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
        ,
        .TIMEOUT      (TMO)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .ack            (ack),
        .din            (din),
        .count          (count),
        .err_count      (err_count),
        .first_err_idx  (first_err_idx),
        .first_err_data (first_err_data),
        .run_cycles     (run_cycles),
        .proto_err      (proto_err),
        .done           (done),
        .pass           (pass)
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
        ,
        .timeout        (timeout)
`endif
    );

    function automatic logic [31:0] golden(input int unsigned i);
        return 32'(INIT + i * STEP);
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {1'b0, v[7:1]} ^ (v[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // behavioural model: phase 0 idle, 1 run, 2 done
    int          m_ph = 0;
    bit          m_valid = 1'b0;
    logic [31:0] m_cnt, m_err, m_fidx, m_fdata, m_run, m_idle;
    logic        m_proto, m_req, m_reqp, m_pass, m_to;
    logic [7:0]  m_lfsr;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b1;
            m_ph    = 0;
            {m_cnt, m_err, m_fidx, m_fdata, m_run, m_idle} = '0;
            {m_proto, m_req, m_reqp, m_pass, m_to} = '0;
            m_lfsr  = (SEED == 8'h00) ? 8'h01 : SEED;
        end else if (m_valid) begin
            int nph;
            nph = m_ph;
            if (ack && (m_ph != 1 || !m_reqp)) m_proto = 1'b1;
            if (m_ph == 0) begin
                nph = 1;
            end else if (m_ph == 1) begin
                m_run = sat(m_run);
                if (ack) begin
                    if (din !== golden(m_cnt)) begin
                        if (m_err == 0) begin
                            m_fidx  = m_cnt;
                            m_fdata = din;
                        end
                        m_err = sat(m_err);
                    end
                    m_cnt  = sat(m_cnt);
                    m_idle = 0;
                    if (m_cnt == MAXC) nph = 2;
                end else begin
                    m_idle = sat(m_idle);
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
                    if (m_idle >= TMO) begin
                        nph  = 2;
                        m_to = 1'b1;
                    end
`endif
                end
            end
            m_reqp = m_req;
            m_req  = (nph == 1) && (m_lfsr >= THR);
            m_lfsr = lfsr_next(m_lfsr);
            m_ph   = nph;
            m_pass = (nph == 2) && (m_err == 0) && !m_proto && !m_to;
        end
    end

    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            chk("cyc_req", req, m_req);
            chk("cyc_count", count, m_cnt);
            chk("cyc_err_count", err_count, m_err);
            chk("cyc_first_err_idx", first_err_idx, m_fidx);
            chk("cyc_first_err_data", first_err_data, m_fdata);
            chk("cyc_run_cycles", run_cycles, m_run);
            chk("cyc_proto_err", proto_err, m_proto);
            chk("cyc_done", done, m_ph == 2);
            chk("cyc_pass", pass, m_pass);
`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
            chk("cyc_timeout", timeout, m_to);
`endif
        end
    end

    // upstream producer
    int   widx = 0;
    logic cur_req = 1'b0;
    logic prev_req = 1'b0;
    logic up_en = 1'b1;
    logic inj_pend = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        prev_req = cur_req;
        cur_req  = req;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ack = 1'b0;
        tick();
        rst      = 1'b0;
        widx     = 0;
        cur_req  = 1'b0;
        prev_req = 1'b0;
    endtask

    task automatic drive(input int bad);
        logic go;
        go = up_en && prev_req && (widx < MAXC)
           && ($urandom_range(0, 3) != 0);
        if (up_en && inj_pend && !prev_req && widx >= 50 && widx < MAXC) begin
            go       = 1'b1;
            inj_pend = 1'b0;
        end
        if (go) begin
            ack = 1'b1;
            din = (widx == bad) ? 32'd99 : golden(widx);
            widx++;
        end else begin
            ack = 1'b0;
            din = $urandom;
        end
    endtask

    task automatic run_to_done(input int bad, input logic inject,
                               input int stop_at, output int ticks,
                               output int hi, output logic [3:0] head);
        ticks    = 0;
        hi       = 0;
        head     = '0;
        inj_pend = inject;
        forever begin
            tick();
            ticks++;
            if (ticks <= 4) head = {head[2:0], cur_req};
            if (done) break;
            if (cur_req) hi++;
            if (stop_at >= 0 && widx >= stop_at) break;
            if (ticks > BUDGET) begin
                chk("done_within_budget", 0, 1);
                break;
            end
            drive(bad);
        end
        ack = 1'b0;
    endtask

    initial begin
        int         ticks, hi;
        logic [3:0] head;

        do_reset();
        chk("rst_req", req, 0);
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);

        // clean run with back-pressure
        run_to_done(-1, 1'b0, -1, ticks, hi, head);
        chk("a_done", done, 1);
        chk("a_pass", pass, 1);
        chk("a_count", count, 5000);
        chk("a_err_count", err_count, 0);
        chk("a_run_cycles", run_cycles, ticks - 1);
        chk("a_req_head", head, 4'b1101);
        chk("a_req_duty", (hi * 10 >= (ticks - 1) * 3)
                       && (hi * 10 <= (ticks - 1) * 7), 1);

        // word 7 corrupted to 99
        do_reset();
        run_to_done(7, 1'b0, -1, ticks, hi, head);
        chk("b_err_count", err_count, 1);
        chk("b_first_err_idx", first_err_idx, 7);
        chk("b_first_err_data", first_err_data, 99);
        chk("b_done", done, 1);
        chk("b_pass", pass, 0);

        // ack injected after a req-low cycle, then an overrun ack
        do_reset();
        run_to_done(-1, 1'b1, -1, ticks, hi, head);
        chk("c_proto_err", proto_err, 1);
        chk("c_pass", pass, 0);
        ack = 1'b1;
        din = $urandom;
        tick();
        ack = 1'b0;
        tick();
        chk("c_overrun_count", count, 5000);
        chk("c_overrun_proto", proto_err, 1);
        chk("c_overrun_pass", pass, 0);

        // reset after 100 words, then a full clean run
        do_reset();
        run_to_done(-1, 1'b0, 100, ticks, hi, head);
        chk("d_pre_reset_count", count, 100);
        do_reset();
        chk("d_count", count, 0);
        chk("d_err_count", err_count, 0);
        chk("d_first_err_idx", first_err_idx, 0);
        chk("d_first_err_data", first_err_data, 0);
        chk("d_run_cycles", run_cycles, 0);
        chk("d_proto_err", proto_err, 0);
        chk("d_done", done, 0);
        chk("d_pass", pass, 0);
        chk("d_req", req, 0);
        run_to_done(-1, 1'b0, -1, ticks, hi, head);
        chk("d_req_head", head, 4'b1101);
        chk("d_count_final", count, 5000);
        chk("d_pass_final", pass, 1);

`ifdef STREAM_SINK_CHECKER_TIMEOUT_EN
        // silent upstream trips the watchdog
        up_en = 1'b0;
        do_reset();
        run_to_done(-1, 1'b0, -1, ticks, hi, head);
        chk("e_timeout", timeout, 1);
        chk("e_done", done, 1);
        chk("e_pass", pass, 0);
        chk("e_run_cycles", run_cycles, TMO);
        up_en = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
